// File: rtl/lsu_pkg.sv
// Shared load/store definitions: mem_ctrl encodings, FSM states, access sizes.
package lsu_pkg;

  localparam int XLEN        = 32;
  localparam int TIMEOUT_DEF = 16;

  localparam logic [2:0] MEM_LB  = 3'b000;
  localparam logic [2:0] MEM_LH  = 3'b001;
  localparam logic [2:0] MEM_LW  = 3'b010;
  localparam logic [2:0] MEM_LBU = 3'b011;
  localparam logic [2:0] MEM_LHU = 3'b100;
  localparam logic [2:0] MEM_SB  = 3'b101;
  localparam logic [2:0] MEM_SH  = 3'b110;
  localparam logic [2:0] MEM_SW  = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_DONE} lsu_state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_e;

  function automatic logic ctrl_is_store(input logic [2:0] ctrl);
    return (ctrl == MEM_SB) || (ctrl == MEM_SH) || (ctrl == MEM_SW);
  endfunction

  function automatic mem_size_e ctrl_size(input logic [2:0] ctrl);
    case (ctrl)
      MEM_LB, MEM_LBU, MEM_SB: return SZ_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: return SZ_HALF;
      default:                 return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus: request/grant for the command, rvalid for read data.
interface lsu_if;
  import lsu_pkg::*;

  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [3:0]      bus_be;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_gnt;
  logic            bus_rvalid;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_load_extend.sv
// Picks the addressed byte/halfword out of a bus word and sign- or zero-extends it.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      ctrl_i,
  output logic [XLEN-1:0] result_o
);

  logic [15:0] lane;

  always_comb begin
    lane = 16'(rdata_i >> {offset_i, 3'b000});
    case (ctrl_i)
      MEM_LB:  result_o = {{24{lane[7]}}, lane[7:0]};
      MEM_LH:  result_o = {{16{lane[15]}}, lane[15:0]};
      MEM_LBU: result_o = {24'b0, lane[7:0]};
      MEM_LHU: result_o = {16'b0, lane[15:0]};
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: one bus transaction per decoder command, with
// alignment rejection and a grant/response timeout.
//   state   | meaning
//   IDLE    | waiting for a command; rejects illegal/misaligned ones
//   REQ     | bus_req held with stable fields until bus_gnt
//   RESP    | load granted, waiting for bus_rvalid
//   DONE    | done pulse, command consumed
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_rd_i,
  input  logic            mem_wr_i,
  input  logic [2:0]      mem_ctrl_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            stall_o,
  output logic [XLEN-1:0] ld_data_o,
  output logic            done_o,
  output logic            misalign_o,
  output logic            bus_err_o,
  lsu_if.master           bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e      state_q;
  logic [2:0]      ctrl_q;
  logic [1:0]      off_q;
  logic [CNT_W-1:0] cnt_q;
  logic            done_q, misalign_q, bus_err_q, req_q, we_q;
  logic [XLEN-1:0] baddr_q, bwdata_q, ld_data_q;
  logic [3:0]      be_q;

  logic            cmd_any, reject;
  mem_size_e       acc_size;
  logic [3:0]      be_d;
  logic [XLEN-1:0] bwdata_d, ext;

  assign cmd_any = mem_rd_i | mem_wr_i;

  always_comb begin
    acc_size = ctrl_size(mem_ctrl_i);
    reject   = (mem_rd_i & mem_wr_i)
             | (mem_rd_i & ctrl_is_store(mem_ctrl_i))
             | (mem_wr_i & ~ctrl_is_store(mem_ctrl_i))
             | ((acc_size == SZ_HALF) & addr_i[0])
             | ((acc_size == SZ_WORD) & (addr_i[1:0] != 2'b00));
    case (acc_size)
      SZ_BYTE: begin
        be_d     = 4'b0001 << addr_i[1:0];
        bwdata_d = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        be_d     = 4'b0011 << addr_i[1:0];
        bwdata_d = {2{wdata_i[15:0]}};
      end
      default: begin
        be_d     = 4'b1111;
        bwdata_d = wdata_i;
      end
    endcase
  end

  lsu_load_extend u_ext (
    .rdata_i  (bus.bus_rdata),
    .offset_i (off_q),
    .ctrl_i   (ctrl_q),
    .result_o (ext)
  );

  // A command seen during an error pulse has already been answered, so IDLE skips it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      baddr_q    <= '0;
      bwdata_q   <= '0;
      be_q       <= '0;
      ld_data_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_any && !misalign_q && !bus_err_q) begin
            if (reject) begin
              misalign_q <= 1'b1;
            end else begin
              ctrl_q   <= mem_ctrl_i;
              off_q    <= addr_i[1:0];
              we_q     <= mem_wr_i;
              baddr_q  <= {addr_i[XLEN-1:2], 2'b00};
              be_q     <= be_d;
              bwdata_q <= mem_wr_i ? bwdata_d : '0;
              req_q    <= 1'b1;
              cnt_q    <= '0;
              state_q  <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus.bus_gnt) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= we_q;
            state_q <= we_q ? ST_DONE : ST_RESP;
          end else if (cnt_q == CNT_LAST) begin
            req_q     <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.bus_rvalid) begin
            ld_data_q <= ext;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            bus_err_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall_o = (cmd_any && (state_q != ST_DONE) && !misalign_q && !bus_err_q)
                 || (state_q == ST_REQ) || (state_q == ST_RESP);

  assign ld_data_o     = ld_data_q;
  assign done_o        = done_q;
  assign misalign_o    = misalign_q;
  assign bus_err_o     = bus_err_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = baddr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = bwdata_q;

endmodule
